dir_cmd_arbiter: RTL and testbench
==================================

DIR_CMD_ARBITER -- requirements
Module: dir_cmd_arbiter

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO depth; power of 2, at least 2.
REQ-002 Parameter CNT_W, default 3, width of fifo_count; equals clog2(DEPTH+1).
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 flush  input  1  synchronous clear, driven high while game is idle.
REQ-006 mov_tick  input  1  one-cycle pulse per snake step.
REQ-007 req_valid  input  3  per-requester valid: bit0 board buttons, bit1 PS/2 keyboard, bit2 online.
REQ-008 req_dir  input  6  direction per requester: bits[2i+1:2i] for requester i.
REQ-009 cmd_accept  output  3  one-hot grant, combinational.
REQ-010 dir_state  output  2  committed direction: 00 up, 01 down, 10 left, 11 right.
REQ-011 fifo_count  output  CNT_W  number of queued commands, 0..DEPTH.
REQ-012 drop_cnt  output  8  saturating count of discarded commands.

Function
REQ-013 Handshake: a requester holds req_valid and req_dir stable until its cmd_accept bit is seen high at a rising edge; that edge consumes the request.
REQ-014 Grant rule: at most one cmd_accept bit is high per cycle, chosen round-robin from pointer rr (0..2), searching rr, rr+1, rr+2 mod 3.
REQ-015 After a grant to requester g, rr becomes (g+1) mod 3; with no grant, rr is unchanged.
REQ-016 No grant is issued when fifo_count==DEPTH and mov_tick==0 (backpressure); requests wait.
REQ-017 When fifo_count==DEPTH and mov_tick==1, a grant is allowed in the same cycle (pop frees a slot).
REQ-018 No grant is issued in any cycle with flush==1.
REQ-019 Reference direction: the FIFO tail entry if fifo_count>0, otherwise dir_state.
REQ-020 A granted command equal to, or opposite to, the reference direction (up/down, left/right) is discarded: accept still pulses, no FIFO write, drop_cnt increments, saturating at 255.
REQ-021 Any other granted command is written at the FIFO tail at the consuming edge.
REQ-022 Pop: on mov_tick with fifo_count>0, the head entry is loaded into dir_state at that edge and removed; dir_state is visible the cycle after the tick.
REQ-023 mov_tick with an empty FIFO leaves dir_state unchanged.
REQ-024 A simultaneous push and pop in one cycle leaves fifo_count unchanged; the pushed entry lands behind the remaining entries.
REQ-025 A push into an empty FIFO and a mov_tick in the same cycle do not bypass: dir_state is unchanged and the entry is popped on a later tick.
REQ-026 FIFO read/write pointers wrap modulo DEPTH; fifo_count never exceeds DEPTH or underflows.
REQ-027 flush==1 at an edge sets: FIFO empty, fifo_count=0, dir_state=11, rr=0; it overrides mov_tick and requests; drop_cnt is kept.

Reset
REQ-028 rst_n low asynchronously sets dir_state=11, fifo_count=0, FIFO pointers=0, rr=0, drop_cnt=0.
REQ-029 While rst_n is low, cmd_accept=000.
REQ-030 Release of rst_n mid-request: the first grant may occur at the first edge after release.
REQ-031 Memory contents need not be reset.

Verification
REQ-032 Reset, then req_valid=001 with dir=00 (up), then mov_tick -> accept=001 for one cycle, fifo_count 0->1->0, dir_state=00 the cycle after the tick.
REQ-033 dir_state=11; keyboard requests 10 (left) -> accept=010, drop_cnt=1, fifo_count stays 0, dir_state stays 11.
REQ-034 All three valid and held (dirs 00, 01, 00 for requesters 0, 1, 2), rr=0 -> grants in order 001, 010, 100; the second (01) is dropped as opposite of the tail 00; the third (00) is dropped as equal to the tail; fifo_count=1.
REQ-035 DEPTH=4, FIFO filled with alternating 00/10, requester still valid -> accept=000; a mov_tick pulse in the same cycle -> accept asserts, fifo_count stays 4.
REQ-036 fifo_count=3, flush=1 together with mov_tick and req_valid=111 -> accept=000, fifo_count=0, dir_state=11, drop_cnt unchanged.
REQ-037 rst_n pulled low mid-sequence (fifo_count=2, drop_cnt=5) -> all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/dir_cmd_if.sv
// Request/grant bundle between the three direction sources and the arbiter.
interface dir_cmd_if;
    logic [2:0] req_valid;
    logic [5:0] req_dir;
    logic [2:0] cmd_accept;

    modport master (
        output req_valid,
        output req_dir,
        input  cmd_accept
    );

    modport slave (
        input  req_valid,
        input  req_dir,
        output cmd_accept
    );
endinterface

// File: rtl/dir_cmd_arbiter.sv
// Round-robin arbiter for snake direction commands feeding a small FIFO that is
// drained one entry per movement tick into the committed direction.
module dir_cmd_arbiter #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             mov_tick,
    dir_cmd_if.slave         bus,
    output logic [1:0]       dir_state,
    output logic [CNT_W-1:0] fifo_count,
    output logic [7:0]       drop_cnt
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned N_REQ = 3;
    localparam logic [1:0]  DIR_RIGHT = 2'b11;

    logic [1:0]       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] tail_ptr;
    logic [1:0]       rr;

    logic             empty;
    logic             full;
    logic             grant_ok;
    logic             grant_any;
    logic [1:0]       gidx;
    logic [1:0]       gdir;
    logic [1:0]       ref_dir;
    logic             drop;
    logic             push;
    logic             pop;
    logic [2:0]       accept_c;

    // FIFO status and the direction a new command is judged against
    always_comb begin
        empty    = (fifo_count == '0);
        full     = (fifo_count == CNT_W'(DEPTH));
        tail_ptr = wr_ptr - PTR_W'(1);
        ref_dir  = empty ? dir_state : mem[tail_ptr];
        grant_ok = !flush && (!full || mov_tick);
    end

    // Round-robin search starting at rr
    always_comb begin
        logic [1:0] cand;
        grant_any = 1'b0;
        gidx      = 2'd0;
        cand      = rr;
        if (grant_ok) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                cand = 2'((32'(rr) + k) % N_REQ);
                if (!grant_any && bus.req_valid[cand]) begin
                    grant_any = 1'b1;
                    gidx      = cand;
                end
            end
        end
    end

    // Same or opposite direction share the axis bit, so one compare covers both
    always_comb begin
        accept_c = 3'b000;
        gdir     = bus.req_dir[{gidx, 1'b0} +: 2];
        drop     = (gdir[1] == ref_dir[1]);
        push     = grant_any && !drop;
        pop      = mov_tick && !empty && !flush;
        if (grant_any) begin
            accept_c[gidx] = 1'b1;
        end
        bus.cmd_accept = rst_n ? accept_c : 3'b000;
    end

    // Entry storage carries no reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= gdir;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            dir_state  <= DIR_RIGHT;
            rr         <= 2'd0;
            drop_cnt   <= 8'd0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            dir_state  <= DIR_RIGHT;
            rr         <= 2'd0;
        end else begin
            if (grant_any) begin
                rr <= (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;
            end
            if (grant_any && drop && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            // Pop only sees entries present before this edge, so no bypass
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                dir_state <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule

// File: tb/tb_dir_cmd_arbiter.sv
// Self-checking bench for dir_cmd_arbiter: directed scenarios plus randomized
// traffic compared against a queue-based model of the command rules.
module tb_dir_cmd_arbiter;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             mov_tick;
    logic [1:0]       dir_state;
    logic [CNT_W-1:0] fifo_count;
    logic [7:0]       drop_cnt;

    dir_cmd_if bus ();

    dir_cmd_arbiter #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .mov_tick   (mov_tick),
        .bus        (bus),
        .dir_state  (dir_state),
        .fifo_count (fifo_count),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [1:0] q[$];
    logic [1:0] m_dir;
    int         m_rr;
    int         m_drop;

    int         checks;
    int         passes;
    logic [2:0] acc_act;
    logic [2:0] acc_exp;

    task automatic model_reset();
        q.delete();
        m_dir  = 2'b11;
        m_rr   = 0;
        m_drop = 0;
    endtask

    function automatic logic [2:0] model_accept();
        if (!rst_n || flush) return 3'b000;
        if (q.size() == DEPTH && !mov_tick) return 3'b000;
        for (int k = 0; k < 3; k++) begin
            int r;
            r = (m_rr + k) % 3;
            if (bus.req_valid[r]) return 3'b001 << r;
        end
        return 3'b000;
    endfunction

    task automatic model_commit(input logic [2:0] acc);
        logic [1:0] d;
        logic [1:0] ref_d;
        bit         do_pop;
        bit         do_push;
        int         g;
        if (flush) begin
            q.delete();
            m_dir = 2'b11;
            m_rr  = 0;
            return;
        end
        ref_d   = (q.size() > 0) ? q[q.size()-1] : m_dir;
        do_pop  = mov_tick && (q.size() > 0);
        do_push = 1'b0;
        d       = 2'b00;
        if (acc != 3'b000) begin
            g    = acc[0] ? 0 : (acc[1] ? 1 : 2);
            d    = bus.req_dir[2*g +: 2];
            m_rr = (g + 1) % 3;
            if (d == ref_d || d == (ref_d ^ 2'b01))
                m_drop = (m_drop < 255) ? m_drop + 1 : 255;
            else
                do_push = 1'b1;
        end
        if (do_pop) m_dir = q.pop_front();
        if (do_push) q.push_back(d);
    endtask

    // One clock: drive at negedge, sample accept, advance model, sample registers
    task automatic apply(input logic [2:0] v, input logic [5:0] d, input bit t, input bit f);
        @(negedge clk);
        bus.req_valid = v;
        bus.req_dir   = d;
        mov_tick      = t;
        flush         = f;
        #1;
        acc_act = bus.cmd_accept;
        acc_exp = model_accept();
        @(posedge clk);
        model_commit(acc_exp);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        mov_tick = 1'b0;
        bus.req_valid = 3'b111;
        bus.req_dir = 6'b000000;
        model_reset();
        #12;
        checks++; if (bus.cmd_accept !== 3'b000) $display("FAIL reset_accept: got %b want 000", bus.cmd_accept); else passes++;
        checks++; if (dir_state !== 2'b11) $display("FAIL reset_dir: got %b want 11", dir_state); else passes++;
        checks++; if (fifo_count !== CNT_W'(0)) $display("FAIL reset_count: got %0d want 0", fifo_count); else passes++;
        checks++; if (drop_cnt !== 8'd0) $display("FAIL reset_drop: got %0d want 0", drop_cnt); else passes++;
        @(negedge clk);
        bus.req_valid = 3'b000;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        apply(3'b001, 6'b000000, 1'b0, 1'b0);
        checks++; if (acc_act !== 3'b001) $display("FAIL basic_accept: got %b want 001", acc_act); else passes++;
        checks++; if (fifo_count !== CNT_W'(1)) $display("FAIL basic_count1: got %0d want 1", fifo_count); else passes++;
        checks++; if (dir_state !== 2'b11) $display("FAIL basic_dir_before_tick: got %b want 11", dir_state); else passes++;
        apply(3'b000, 6'b000000, 1'b1, 1'b0);
        checks++; if (acc_act !== 3'b000) $display("FAIL basic_idle_accept: got %b want 000", acc_act); else passes++;
        checks++; if (fifo_count !== CNT_W'(0)) $display("FAIL basic_count0: got %0d want 0", fifo_count); else passes++;
        checks++; if (dir_state !== 2'b00) $display("FAIL basic_dir_after_tick: got %b want 00", dir_state); else passes++;
    endtask

    task automatic test_drop();
        int d0;
        apply(3'b000, 6'b000000, 1'b0, 1'b1);
        d0 = m_drop;
        apply(3'b010, 6'b001000, 1'b0, 1'b0);
        checks++; if (acc_act !== 3'b010) $display("FAIL drop_accept: got %b want 010", acc_act); else passes++;
        checks++; if (drop_cnt !== 8'(d0 + 1)) $display("FAIL drop_cnt: got %0d want %0d", drop_cnt, d0 + 1); else passes++;
        checks++; if (fifo_count !== CNT_W'(0)) $display("FAIL drop_count: got %0d want 0", fifo_count); else passes++;
        checks++; if (dir_state !== 2'b11) $display("FAIL drop_dir: got %b want 11", dir_state); else passes++;
    endtask

    task automatic test_round_robin();
        int d0;
        apply(3'b000, 6'b000000, 1'b0, 1'b1);
        d0 = m_drop;
        apply(3'b111, 6'b000100, 1'b0, 1'b0);
        checks++; if (acc_act !== 3'b001) $display("FAIL rr_first: got %b want 001", acc_act); else passes++;
        apply(3'b110, 6'b000100, 1'b0, 1'b0);
        checks++; if (acc_act !== 3'b010) $display("FAIL rr_second: got %b want 010", acc_act); else passes++;
        apply(3'b100, 6'b000100, 1'b0, 1'b0);
        checks++; if (acc_act !== 3'b100) $display("FAIL rr_third: got %b want 100", acc_act); else passes++;
        checks++; if (fifo_count !== CNT_W'(1)) $display("FAIL rr_count: got %0d want 1", fifo_count); else passes++;
        checks++; if (drop_cnt !== 8'(d0 + 2)) $display("FAIL rr_drop: got %0d want %0d", drop_cnt, d0 + 2); else passes++;
    endtask

    task automatic test_full_backpressure();
        apply(3'b000, 6'b000000, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) apply(3'b001, (i % 2 == 0) ? 6'b000000 : 6'b000010, 1'b0, 1'b0);
        checks++; if (fifo_count !== CNT_W'(4)) $display("FAIL full_count: got %0d want 4", fifo_count); else passes++;
        apply(3'b001, 6'b000000, 1'b0, 1'b0);
        checks++; if (acc_act !== 3'b000) $display("FAIL full_block: got %b want 000", acc_act); else passes++;
        checks++; if (fifo_count !== CNT_W'(4)) $display("FAIL full_hold: got %0d want 4", fifo_count); else passes++;
        apply(3'b001, 6'b000000, 1'b1, 1'b0);
        checks++; if (acc_act !== 3'b001) $display("FAIL full_tick_accept: got %b want 001", acc_act); else passes++;
        checks++; if (fifo_count !== CNT_W'(4)) $display("FAIL full_tick_count: got %0d want 4", fifo_count); else passes++;
        checks++; if (dir_state !== 2'b00) $display("FAIL full_tick_dir: got %b want 00", dir_state); else passes++;
    endtask

    task automatic test_flush();
        int d0;
        apply(3'b000, 6'b000000, 1'b0, 1'b1);
        apply(3'b001, 6'b000000, 1'b0, 1'b0);
        apply(3'b001, 6'b000010, 1'b0, 1'b0);
        apply(3'b001, 6'b000000, 1'b0, 1'b0);
        checks++; if (fifo_count !== CNT_W'(3)) $display("FAIL flush_pre_count: got %0d want 3", fifo_count); else passes++;
        d0 = m_drop;
        apply(3'b111, 6'b110110, 1'b1, 1'b1);
        checks++; if (acc_act !== 3'b000) $display("FAIL flush_accept: got %b want 000", acc_act); else passes++;
        checks++; if (fifo_count !== CNT_W'(0)) $display("FAIL flush_count: got %0d want 0", fifo_count); else passes++;
        checks++; if (dir_state !== 2'b11) $display("FAIL flush_dir: got %b want 11", dir_state); else passes++;
        checks++; if (drop_cnt !== 8'(d0)) $display("FAIL flush_drop: got %0d want %0d", drop_cnt, d0); else passes++;
    endtask

    task automatic test_async_reset();
        apply(3'b000, 6'b000000, 1'b0, 1'b1);
        apply(3'b001, 6'b000000, 1'b0, 1'b0);
        apply(3'b001, 6'b000010, 1'b0, 1'b0);
        for (int i = 0; i < 10 && m_drop < 5; i++) apply(3'b001, 6'b000010, 1'b0, 1'b0);
        checks++; if (fifo_count !== CNT_W'(2)) $display("FAIL ares_pre_count: got %0d want 2", fifo_count); else passes++;
        checks++; if (drop_cnt !== 8'd5) $display("FAIL ares_pre_drop: got %0d want 5", drop_cnt); else passes++;
        @(negedge clk);
        bus.req_valid = 3'b001;
        bus.req_dir = 6'b000000;
        mov_tick = 1'b0;
        flush = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.cmd_accept !== 3'b000) $display("FAIL ares_accept: got %b want 000", bus.cmd_accept); else passes++;
        checks++; if (dir_state !== 2'b11) $display("FAIL ares_dir: got %b want 11", dir_state); else passes++;
        checks++; if (fifo_count !== CNT_W'(0)) $display("FAIL ares_count: got %0d want 0", fifo_count); else passes++;
        checks++; if (drop_cnt !== 8'd0) $display("FAIL ares_drop: got %0d want 0", drop_cnt); else passes++;
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
        apply(3'b001, 6'b000000, 1'b0, 1'b0);
        checks++; if (acc_act !== 3'b001) $display("FAIL ares_first_grant: got %b want 001", acc_act); else passes++;
        checks++; if (fifo_count !== CNT_W'(1)) $display("FAIL ares_first_count: got %0d want 1", fifo_count); else passes++;
    endtask

    task automatic test_random();
        logic [2:0] pend_v;
        logic [5:0] pend_d;
        bit         t;
        bit         f;
        pend_v = 3'b000;
        pend_d = 6'b000000;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 3; i++) begin
                if (!pend_v[i] && ($urandom % 3 == 0)) begin
                    pend_v[i] = 1'b1;
                    pend_d[2*i +: 2] = 2'($urandom % 4);
                end
            end
            t = ($urandom % 4 == 0);
            f = ($urandom % 80 == 0);
            apply(pend_v, pend_d, t, f);
            checks++; if (acc_act !== acc_exp) $display("FAIL rnd_accept cyc %0d: got %b want %b", n, acc_act, acc_exp); else passes++;
            checks++; if (dir_state !== m_dir) $display("FAIL rnd_dir cyc %0d: got %b want %b", n, dir_state, m_dir); else passes++;
            checks++; if (fifo_count !== CNT_W'(q.size())) $display("FAIL rnd_count cyc %0d: got %0d want %0d", n, fifo_count, q.size()); else passes++;
            checks++; if (drop_cnt !== 8'(m_drop)) $display("FAIL rnd_drop cyc %0d: got %0d want %0d", n, drop_cnt, m_drop); else passes++;
            pend_v = pend_v & ~acc_exp;
        end
        checks++; if (drop_cnt !== 8'd255) $display("FAIL rnd_saturate: got %0d want 255", drop_cnt); else passes++;
    endtask

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_basic();
        test_drop();
        test_round_robin();
        test_full_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
